// File: rtl/conv_offset_pkg.sv
// ---------------------------------------------------------------------------
// conv_offset_pkg
// Shared definitions for the convolution offset sequencer:
//   - mode_t and the four burst modes decoded from the controller's mode input
//   - state_t, the three-state burst FSM encoding
//   - idx_width(), width of an index able to count 0..n-1 (never below 1 bit)
// ---------------------------------------------------------------------------
package conv_offset_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FILTER = 2'b00;
    localparam mode_t MODE_STORE  = 2'b01;
    localparam mode_t MODE_LINE   = 2'b10;
    localparam mode_t MODE_NOP    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // $clog2(1) is 0; a zero-width index is not legal, so clamp to 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_offset_sequencer_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// W-bit counter with natural modulo-2^W wrap. Used for the line-buffer write
// pointer, the line-buffer read base and the burst beat index.
// Priority: rst / clear > load > increment.
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-high reset (count -> 0)
//   clear     in  1  synchronous clear (count -> 0)
//   load      in  1  load load_val
//   load_val  in  W  value to load
//   inc       in  1  add amount
//   amount    in  W  increment step
//   count     out W  current value
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] amount,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            // W-bit sum drops the carry: wrap is modulo 2^W by construction.
            count <= count + amount;
        end
    end

endmodule

// File: rtl/conv_offset_sequencer.sv
// ---------------------------------------------------------------------------
// conv_offset_sequencer
// Issues offset bursts for the convolution datapath: filter-memory reads,
// single-beat stores into a circular line buffer, and line-buffer window reads
// that advance by a runtime stride. Beats use a valid/ready handshake.
// Ports:
//   clk        in  1          rising-edge clock
//   rst        in  1          synchronous active-high reset
//   start      in  1          burst request, sampled only in IDLE
//   mode       in  2          00 filter, 01 store, 10 line, 11 nop
//   stride     in  STRIDE_W   window advance for line reads
//   off_valid  out 1          off_val / off_last valid
//   off_ready  in  1          consumer accepts the current beat
//   off_val    out ADDR_W     current offset (0 when not valid)
//   off_last   out 1          final beat of the burst
//   busy       out 1          high in RUN and DONE
//   done       out 1          one-cycle pulse after the last handshake
//   err        out 1          one-cycle pulse when a start is rejected
//   occupancy  out PTR_W+1    valid line-buffer entries
// ---------------------------------------------------------------------------
module conv_offset_sequencer
    import conv_offset_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int FILTER_LEN  = 4,
    parameter int LINE_LEN    = 4,
    parameter int STORE_DEPTH = 16,
    parameter int STRIDE_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [STRIDE_W-1:0]          stride,
    output logic                         off_valid,
    input  logic                         off_ready,
    output logic [ADDR_W-1:0]            off_val,
    output logic                         off_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(STORE_DEPTH):0] occupancy
);

    localparam int PTR_W    = $clog2(STORE_DEPTH);
    localparam int OCC_W    = PTR_W + 1;
    localparam int BEAT_MAX = (FILTER_LEN > LINE_LEN) ? FILTER_LEN : LINE_LEN;
    localparam int BEAT_W   = idx_width(BEAT_MAX);

    state_t              state;
    mode_t               mode_q;
    logic [STRIDE_W-1:0] stride_q;

    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] last_idx;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_base;
    logic [PTR_W-1:0]  line_addr;

    logic start_ok;
    logic start_bad;
    logic hs;
    logic beat_last;
    logic hs_last;

    // ------------------------------------------------------------------
    // Start qualification (only meaningful in IDLE)
    // ------------------------------------------------------------------
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        start_ok  = 1'b0;
        start_bad = 1'b0;
        if (state == ST_IDLE && start) begin
            case (mode)
                MODE_FILTER: start_ok = 1'b1;
                MODE_STORE: begin
                    if (occupancy == OCC_W'(STORE_DEPTH)) start_bad = 1'b1;
                    else                                  start_ok  = 1'b1;
                end
                MODE_LINE: begin
                    // A window needs LINE_LEN entries present, and the stride
                    // must retire at least one and at most the entries read.
                    if (occupancy < OCC_W'(LINE_LEN) || stride == '0 ||
                        32'(stride) > LINE_LEN)
                        start_bad = 1'b1;
                    else
                        start_ok  = 1'b1;
                end
                default: ; // NOP: silently ignored
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        last_idx = '0;
        case (mode_q)
            MODE_FILTER: last_idx = BEAT_W'(FILTER_LEN - 1);
            MODE_LINE:   last_idx = BEAT_W'(LINE_LEN - 1);
            default:     last_idx = '0; // store is a single beat
        endcase
    end

    assign hs        = off_valid & off_ready;
    assign beat_last = (beat == last_idx);
    assign hs_last   = hs & beat_last;
    assign off_last  = off_valid & beat_last;

    // Beat index restarts on every accepted start; it only moves on a
    // handshake, so off_val/off_last hold while the consumer stalls.
    wrap_counter #(.W(BEAT_W)) u_beat (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .load     (1'b0),
        .load_val ('0),
        .inc      (hs & ~beat_last),
        .amount   (BEAT_W'(1)),
        .count    (beat)
    );

    wrap_counter #(.W(PTR_W)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .inc      (hs && mode_q == MODE_STORE),
        .amount   (PTR_W'(1)),
        .count    (wr_ptr)
    );

    // Stride never exceeds LINE_LEN <= STORE_DEPTH, so truncating it to
    // PTR_W bits gives the correct modulo advance (STORE_DEPTH -> 0).
    wrap_counter #(.W(PTR_W)) u_rd_base (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .inc      (hs_last && mode_q == MODE_LINE),
        .amount   (PTR_W'(stride_q)),
        .count    (rd_base)
    );

    assign line_addr = rd_base + PTR_W'(beat);

    // ------------------------------------------------------------------
    // Offset mux: zero unless a beat is being presented
    // ------------------------------------------------------------------
    always_comb begin
        off_val = '0;
        if (off_valid) begin
            case (mode_q)
                MODE_FILTER: off_val = ADDR_W'(beat);
                MODE_STORE:  off_val = ADDR_W'(wr_ptr);
                MODE_LINE:   off_val = ADDR_W'(line_addr);
                default:     off_val = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM, latched request and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_FILTER;
            stride_q  <= '0;
            off_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            occupancy <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_RUN;
                        mode_q    <= mode;
                        stride_q  <= stride;
                        off_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else if (start_bad) begin
                        err <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (mode_q == MODE_STORE)
                            occupancy <= occupancy + OCC_W'(1);
                        if (beat_last) begin
                            if (mode_q == MODE_LINE)
                                occupancy <= occupancy - OCC_W'(stride_q);
                            off_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_offset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_offset_sequencer
// Directed bursts; expected beats are pushed into a queue when a start is
// issued and a monitor pops and compares them on every handshake (and checks
// hold on every stalled cycle).
// ---------------------------------------------------------------------------
module tb_conv_offset_sequencer;
    import conv_offset_pkg::*;

    localparam int ADDR_W      = 16;
    localparam int FILTER_LEN  = 4;
    localparam int LINE_LEN    = 4;
    localparam int STORE_DEPTH = 16;
    localparam int STRIDE_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [1:0]          mode;
    logic [STRIDE_W-1:0] stride;
    logic                off_valid;
    logic                off_ready;
    logic [ADDR_W-1:0]   off_val;
    logic                off_last;
    logic                busy;
    logic                done;
    logic                err;
    logic [4:0]          occupancy;

    typedef struct packed {
        logic        last;
        logic [15:0] val;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_wr = 0;
    int    m_rd = 0;
    int    m_occ = 0;

    always #5 clk = ~clk;

    conv_offset_sequencer #(
        .ADDR_W      (ADDR_W),
        .FILTER_LEN  (FILTER_LEN),
        .LINE_LEN    (LINE_LEN),
        .STORE_DEPTH (STORE_DEPTH),
        .STRIDE_W    (STRIDE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .stride    (stride),
        .off_valid (off_valid),
        .off_ready (off_ready),
        .off_val   (off_val),
        .off_last  (off_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: compare each presented beat with the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0 && off_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got off_val=0x%0h, expected no beat at %0t",
                         off_val, $time);
            end else begin
                check(off_ready ? "beat" : "beat_hold",
                      {15'b0, off_last, off_val}, {15'b0, exp_q[0]});
                if (off_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    // Model the request, queue the beats, pulse start and follow the burst.
    task automatic run_burst(input logic [1:0] md, input int str);
        logic  acc;
        logic  rej;
        beat_t b;
        int    n;
        acc = 1'b0;
        rej = 1'b0;
        case (md)
            MODE_FILTER: acc = 1'b1;
            MODE_STORE:  if (m_occ == STORE_DEPTH) rej = 1'b1; else acc = 1'b1;
            MODE_LINE:   if (m_occ < LINE_LEN || str == 0 || str > LINE_LEN) rej = 1'b1;
                         else acc = 1'b1;
            default: ;
        endcase
        if (acc) begin
            case (md)
                MODE_FILTER: for (int i = 0; i < FILTER_LEN; i++) begin
                    b.last = (i == FILTER_LEN - 1);
                    b.val  = 16'(i);
                    exp_q.push_back(b);
                end
                MODE_STORE: begin
                    b.last = 1'b1;
                    b.val  = 16'(m_wr);
                    exp_q.push_back(b);
                    m_wr  = (m_wr + 1) % STORE_DEPTH;
                    m_occ = m_occ + 1;
                end
                default: begin
                    for (int i = 0; i < LINE_LEN; i++) begin
                        b.last = (i == LINE_LEN - 1);
                        b.val  = 16'((m_rd + i) % STORE_DEPTH);
                        exp_q.push_back(b);
                    end
                    m_rd  = (m_rd + str) % STORE_DEPTH;
                    m_occ = m_occ - str;
                end
            endcase
        end
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = md;
        stride = STRIDE_W'(str);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'b0, err}, {31'b0, rej});
        check("valid_latency", {31'b0, off_valid}, {31'b0, acc});
        check("busy_on_start", {31'b0, busy}, {31'b0, acc});
        if (acc) begin
            n = 0;
            while (done !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("done_seen", {31'b0, done}, 32'd1);
            check("busy_in_done", {31'b0, busy}, 32'd1);
            @(negedge clk);
            check("done_one_cycle", {31'b0, done}, 32'd0);
            check("busy_after", {31'b0, busy}, 32'd0);
        end else begin
            @(negedge clk);
            check("err_one_cycle", {31'b0, err}, 32'd0);
            check("no_valid", {31'b0, off_valid}, 32'd0);
        end
        check("occupancy", {27'b0, occupancy}, 32'(m_occ));
    endtask

    task automatic fill_buffer();
        while (m_occ < STORE_DEPTH) run_burst(MODE_STORE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        stride    = '0;
        off_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_off_valid", {31'b0, off_valid}, 32'd0);
        check("rst_off_last", {31'b0, off_last}, 32'd0);
        check("rst_off_val", {16'b0, off_val}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_occupancy", {27'b0, occupancy}, 32'd0);

        // Filter burst 0..3, NOP ignored, line read from empty buffer rejected.
        run_burst(MODE_FILTER, 0);
        run_burst(MODE_NOP, 0);
        run_burst(MODE_LINE, 2);

        // 16 stores then a rejected 17th.
        for (int i = 0; i < STORE_DEPTH; i++) run_burst(MODE_STORE, 0);
        run_burst(MODE_STORE, 0);

        // Illegal strides.
        run_burst(MODE_LINE, 0);
        run_burst(MODE_LINE, 5);

        // 0,1,2,3 then 2,3,4,5; occupancy 16 -> 14 -> 12.
        run_burst(MODE_LINE, 2);
        run_burst(MODE_LINE, 2);

        // Walk rd_base up to 14, then read across the wrap: 14,15,0,1.
        repeat (5) begin
            fill_buffer();
            run_burst(MODE_LINE, 2);
        end
        fill_buffer();
        run_burst(MODE_LINE, 2);

        // Consumer stalls three cycles on beat 1.
        fill_buffer();
        fork
            run_burst(MODE_LINE, 2);
            begin
                repeat (3) @(posedge clk);
                #1 off_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 off_ready = 1'b1;
            end
        join

        // Largest legal stride.
        fill_buffer();
        run_burst(MODE_LINE, 4);

        // Reset while beat 2 of a line read is presented.
        for (int i = 0; i < 3; i++) begin
            b.last = 1'b0;
            b.val  = 16'((m_rd + i) % STORE_DEPTH);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = MODE_LINE;
        stride = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        off_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_beat2_valid", {31'b0, off_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_off_valid", {31'b0, off_valid}, 32'd0);
        check("midrst_occupancy", {27'b0, occupancy}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        #1;
        rst       = 1'b0;
        off_ready = 1'b1;
        exp_q.delete();
        m_wr  = 0;
        m_rd  = 0;
        m_occ = 0;
        run_burst(MODE_LINE, 2);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
